alu_exec: RTL

//  Execution stage directly downstream of the reservation station. Takes the one-per-cycle

---
 rtl/alu_exec_pkg.sv | 50 +++++
 rtl/alu_exec_if.sv | 30 +++
 rtl/alu_exec_divider.sv | 88 ++++++++
 rtl/alu_exec.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution stage: op encoding, widths,
// ROB "no entry" tag and small op-classification helpers.
// Optional RV32M support is selected with the ALU_MULDIV_EN macro.
package alu_exec_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 6;
  localparam int DEF_ROB_W  = 4;

  localparam logic [DEF_ROB_W-1:0] ZERO_ROB = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ROB_W-1:0]  rob_pos_t;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
    OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } openum_e;

  // Multicycle unit sequencing (only used when RV32M is built in)
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;

  // Immediate forms take operand 2 from the imm field
  function automatic logic is_imm_op(input openum_e op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                      OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU};
  endfunction

  function automatic logic is_branch(input openum_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic is_muldiv(input openum_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_mul(input openum_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Issue/CDB bundle between reservation station, ALU and ROB.
// master = issuing side (RS/ROB), slave = the ALU execution stage.
interface alu_exec_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int ROB_W  = 4
) ();
  logic [OP_W-1:0]   in_rs_op;
  logic [DATA_W-1:0] in_rs_value1;
  logic [DATA_W-1:0] in_rs_value2;
  logic [DATA_W-1:0] in_rs_imm;
  logic [ROB_W-1:0]  in_rs_rob_pos;
  logic [DATA_W-1:0] in_rs_pc;
  logic              in_rob_xbp;
  logic              out_rs_stall;
  logic [ROB_W-1:0]  out_cdb_pos;
  logic [DATA_W-1:0] out_cdb_value;
  logic              out_cdb_jump;
  logic [DATA_W-1:0] out_cdb_target;

  modport master (
    output in_rs_op, in_rs_value1, in_rs_value2, in_rs_imm, in_rs_rob_pos, in_rs_pc, in_rob_xbp,
    input  out_rs_stall, out_cdb_pos, out_cdb_value, out_cdb_jump, out_cdb_target
  );

  modport slave (
    input  in_rs_op, in_rs_value1, in_rs_value2, in_rs_imm, in_rs_rob_pos, in_rs_pc, in_rob_xbp,
    output out_rs_stall, out_cdb_pos, out_cdb_value, out_cdb_jump, out_cdb_target
  );
endinterface

// File: rtl/alu_exec_divider.sv
// Restoring radix-2 divider for the RV32M path: one quotient bit per
// enabled cycle, start/abort control, done pulse, signed result fixup.
// Only compiled when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_exec_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic              busy_reg, done_reg, neg_q_reg, neg_r_reg, div0_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rem_reg, quo_reg, dvs_reg, dividend_reg;
  logic [DATA_W-1:0] abs_a, abs_b, rem_next;
  logic [DATA_W:0]   shifted, diff;
  logic              a_neg, b_neg;

  // Operand magnitudes and one restoring step
  always_comb begin
    a_neg    = is_signed & dividend[DATA_W-1];
    b_neg    = is_signed & divisor[DATA_W-1];
    abs_a    = a_neg ? -dividend : dividend;
    abs_b    = b_neg ? -divisor : divisor;
    shifted  = {rem_reg, quo_reg[DATA_W-1]};
    diff     = shifted - {1'b0, dvs_reg};
    rem_next = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  end

  // Iteration state; abort wins over a pending start
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      dividend_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div0_reg     <= 1'b0;
    end else if (en) begin
      done_reg <= 1'b0;
      if (abort) begin
        busy_reg <= 1'b0;
      end else if (start) begin
        busy_reg     <= 1'b1;
        cnt_reg      <= CNT_W'(DATA_W);
        rem_reg      <= '0;
        quo_reg      <= abs_a;
        dvs_reg      <= abs_b;
        dividend_reg <= dividend;
        neg_q_reg    <= a_neg ^ b_neg;
        neg_r_reg    <= a_neg;
        div0_reg     <= (divisor == '0);
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= {quo_reg[DATA_W-2:0], ~diff[DATA_W]};
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  // Divide-by-zero results bypass sign fixup; -2^31/-1 falls out naturally
  always_comb begin
    quotient  = div0_reg ? '1 : (neg_q_reg ? -quo_reg : quo_reg);
    remainder = div0_reg ? dividend_reg : (neg_r_reg ? -rem_reg : rem_reg);
  end

  assign done = done_reg;

endmodule
`endif

// File: rtl/alu_exec.sv
// ALU execution stage: takes one issued op per cycle, computes the integer
// or branch result and drives it on the ALU CDB for exactly one cycle.
// Define ALU_MULDIV_EN to add multicycle RV32M (multiply/divide) support.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int ROB_W  = DEF_ROB_W
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  alu_exec_if.slave bus
);
  logic [OP_W-1:0]   op_raw;
  openum_e           op;
  logic [DATA_W-1:0] v1, v2, imm, pc, op2, pc4, pc_imm, jalr_sum;
  logic [ROB_W-1:0]  rob;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_value, alu_target;
  logic              alu_jump, stall, op_valid, alu_fire;

  logic [ROB_W-1:0]  cdb_pos_reg;
  logic [DATA_W-1:0] cdb_value_reg, cdb_target_reg;
  logic              cdb_jump_reg;

  assign op_raw = bus.in_rs_op;
  assign op     = openum_e'(op_raw);
  assign v1     = bus.in_rs_value1;
  assign v2     = bus.in_rs_value2;
  assign imm    = bus.in_rs_imm;
  assign pc     = bus.in_rs_pc;
  assign rob    = bus.in_rs_rob_pos;

  // Single-cycle integer/branch result for the op currently on the issue port
  always_comb begin
    op2        = is_imm_op(op) ? imm : v2;
    shamt      = op2[4:0];
    pc4        = pc + DATA_W'(4);
    pc_imm     = pc + imm;
    jalr_sum   = v1 + imm;
    alu_value  = '0;
    alu_jump   = FALSE;
    alu_target = pc4;
    case (op)
      OP_LUI:             alu_value = imm;
      OP_AUIPC:           alu_value = pc_imm;
      OP_JAL: begin
        alu_value  = pc4;
        alu_jump   = TRUE;
        alu_target = pc_imm;
      end
      OP_JALR: begin
        alu_value  = pc4;
        alu_jump   = TRUE;
        alu_target = {jalr_sum[DATA_W-1:1], 1'b0};
      end
      OP_BEQ:             alu_jump = (v1 == v2);
      OP_BNE:             alu_jump = (v1 != v2);
      OP_BLT:             alu_jump = ($signed(v1) <  $signed(v2));
      OP_BGE:             alu_jump = ($signed(v1) >= $signed(v2));
      OP_BLTU:            alu_jump = (v1 <  v2);
      OP_BGEU:            alu_jump = (v1 >= v2);
      OP_ADD,  OP_ADDI:   alu_value = v1 + op2;
      OP_SUB:             alu_value = v1 - op2;
      OP_AND,  OP_ANDI:   alu_value = v1 & op2;
      OP_OR,   OP_ORI:    alu_value = v1 | op2;
      OP_XOR,  OP_XORI:   alu_value = v1 ^ op2;
      OP_SLL,  OP_SLLI:   alu_value = v1 << shamt;
      OP_SRL,  OP_SRLI:   alu_value = v1 >> shamt;
      OP_SRA,  OP_SRAI:   alu_value = DATA_W'($signed(v1) >>> shamt);
      OP_SLT,  OP_SLTI:   alu_value = {{(DATA_W-1){1'b0}}, ($signed(v1) < $signed(op2))};
      OP_SLTU, OP_SLTIU:  alu_value = {{(DATA_W-1){1'b0}}, (v1 < op2)};
      default: ;
    endcase
    if (is_branch(op) && alu_jump) alu_target = pc_imm;
  end

  // An op is taken only when tagged, not flushed and the unit is not busy
  assign op_valid = (op != OP_NOP) && (rob != ZERO_ROB) && !bus.in_rob_xbp && !stall;
  assign alu_fire = op_valid && !is_muldiv(op);

`ifdef ALU_MULDIV_EN
  md_state_e         md_state_reg, md_state_next;
  openum_e           md_op_reg;
  logic [DATA_W-1:0] md_a_reg, md_b_reg, md_pc4_reg, md_result_reg;
  logic [ROB_W-1:0]  md_rob_reg;
  logic              md_phase_reg, md_fire, md_mulh;
  logic [2*DATA_W-1:0] md_prod_reg, md_a_wide, md_b_wide, md_prod;
  logic              div_start, div_done;
  logic [DATA_W-1:0] div_q, div_r;

  assign md_fire = op_valid && is_muldiv(op);
  assign stall   = (md_state_reg != ST_IDLE);

  // Multicycle sequencing: flush always returns to IDLE
  always_comb begin
    md_state_next = md_state_reg;
    div_start     = 1'b0;
    case (md_state_reg)
      ST_IDLE: if (md_fire) begin
        md_state_next = is_mul(op) ? ST_MUL : ST_DIV;
        div_start     = !is_mul(op);
      end
      ST_MUL:  if (md_phase_reg) md_state_next = ST_DONE;
      ST_DIV:  if (div_done) md_state_next = ST_DONE;
      ST_DONE: md_state_next = ST_IDLE;
      default: md_state_next = ST_IDLE;
    endcase
    if (bus.in_rob_xbp) md_state_next = ST_IDLE;
  end

  // Multicycle state register
  always_ff @(posedge clk) begin
    if (!rst) md_state_reg <= ST_IDLE;
    else if (rdy) md_state_reg <= md_state_next;
  end

  // Signed/unsigned extension so the truncated product gives every high-half form
  always_comb begin
    md_a_wide = {{DATA_W{md_a_reg[DATA_W-1] & (md_op_reg inside {OP_MULH, OP_MULHSU})}}, md_a_reg};
    md_b_wide = {{DATA_W{md_b_reg[DATA_W-1] & (md_op_reg == OP_MULH)}}, md_b_reg};
    md_prod   = md_a_wide * md_b_wide;
    md_mulh   = (md_op_reg != OP_MUL);
  end

  // Operand capture, product pipeline and result latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      md_op_reg     <= OP_NOP;
      md_a_reg      <= '0;
      md_b_reg      <= '0;
      md_rob_reg    <= '0;
      md_pc4_reg    <= '0;
      md_phase_reg  <= 1'b0;
      md_prod_reg   <= '0;
      md_result_reg <= '0;
    end else if (rdy) begin
      if (md_fire) begin
        md_op_reg    <= op;
        md_a_reg     <= v1;
        md_b_reg     <= v2;
        md_rob_reg   <= rob;
        md_pc4_reg   <= pc4;
        md_phase_reg <= 1'b0;
      end else if (md_state_reg == ST_MUL) begin
        md_phase_reg <= 1'b1;
        if (!md_phase_reg) md_prod_reg <= md_prod;
        else md_result_reg <= md_mulh ? md_prod_reg[2*DATA_W-1:DATA_W] : md_prod_reg[DATA_W-1:0];
      end else if (md_state_reg == ST_DIV && div_done) begin
        md_result_reg <= (md_op_reg inside {OP_REM, OP_REMU}) ? div_r : div_q;
      end
    end
  end

  alu_exec_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .start     (div_start),
    .abort     (bus.in_rob_xbp),
    .is_signed (op == OP_DIV || op == OP_REM),
    .dividend  (v1),
    .divisor   (v2),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`else
  assign stall = 1'b0;
`endif

  // CDB output register: tag pulses for one cycle, payload holds otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_pos_reg    <= ZERO_ROB;
      cdb_value_reg  <= '0;
      cdb_jump_reg   <= FALSE;
      cdb_target_reg <= '0;
    end else if (rdy) begin
      cdb_pos_reg <= ZERO_ROB;
      if (bus.in_rob_xbp) begin
        cdb_pos_reg <= ZERO_ROB;
`ifdef ALU_MULDIV_EN
      end else if (md_state_reg == ST_DONE) begin
        cdb_pos_reg    <= md_rob_reg;
        cdb_value_reg  <= md_result_reg;
        cdb_jump_reg   <= FALSE;
        cdb_target_reg <= md_pc4_reg;
`endif
      end else if (alu_fire) begin
        cdb_pos_reg    <= rob;
        cdb_value_reg  <= alu_value;
        cdb_jump_reg   <= alu_jump;
        cdb_target_reg <= alu_target;
      end
    end
  end

  assign bus.out_rs_stall   = stall;
  assign bus.out_cdb_pos    = cdb_pos_reg;
  assign bus.out_cdb_value  = cdb_value_reg;
  assign bus.out_cdb_jump   = cdb_jump_reg;
  assign bus.out_cdb_target = cdb_target_reg;

endmodule
